// File: rtl/conv14_pkg.sv
// -----------------------------------------------------------------------------
// conv14_pkg
// Shared definitions for the frame feeder that sits in front of the
// rate-1/2, K=15 convolutional encoder.
//   state_t  : feeder FSM states
//   ENC_MEM  : encoder memory (K-1); default tail and flush length
//   CNT_W    : width of the tail/flush counter (must hold ENC_MEM)
// -----------------------------------------------------------------------------
package conv14_pkg;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        DATA  = 2'd2,
        TAIL  = 2'd3
    } state_t;

    localparam int ENC_MEM = 14;
    localparam int CNT_W   = $clog2(ENC_MEM + 1);

endpackage

// File: rtl/conv14_byte_prefetch.sv
// -----------------------------------------------------------------------------
// conv14_byte_prefetch
// One-entry holding register on the valid/ready byte stream.
// Ports:
//   clock, rst_n   : clock, synchronous active-low reset (empties the entry)
//   i_data/i_last  : incoming byte and its end-of-frame flag
//   i_valid        : incoming byte is valid
//   i_consume      : downstream takes the stored byte this cycle
//   i_block        : refuse new bytes (feeder is flushing)
//   o_ready        : a byte offered this cycle is accepted
//   o_data/o_last  : stored byte and flag
//   o_full         : entry holds a byte
// -----------------------------------------------------------------------------
module conv14_byte_prefetch (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_last,
    input  logic       i_valid,
    input  logic       i_consume,
    input  logic       i_block,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_full
);

    logic [7:0] r_data;
    logic       r_last;
    logic       r_full;
    logic       w_accept;

    // A consume in the same cycle frees the slot, so a new byte can land
    // while the old one leaves without a bubble.
    assign o_ready  = !i_block && (!r_full || i_consume);
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_data <= 8'h00;
            r_last <= 1'b0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_data <= i_data;
            r_last <= i_last;
            r_full <= 1'b1;
        end else if (i_consume) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_last = r_last;
    assign o_full = r_full;

endmodule

// File: rtl/conv14_frame_feeder.sv
// -----------------------------------------------------------------------------
// conv14_frame_feeder
// Serializes payload bytes MSB-first onto the encoder input, one bit per
// clock, appends TAIL_LEN zero bits per frame and drives FLUSH_LEN zeros
// after reset so the (reset-less) encoder starts from an all-zero state.
// Ports:
//   clock, rst_n          : clock, synchronous active-low reset
//   s_data/s_valid/s_last : payload byte stream, s_ready is the handshake
//   enc_in                : registered bit to the encoder input
//   bit_valid             : enc_in belongs to a frame (payload or tail)
//   frame_start           : first payload bit of a frame
//   frame_end             : last tail bit of a frame
//   underrun              : one-cycle pulse, frame aborted for lack of data
// TAIL_LEN and FLUSH_LEN must fit the CNT_W-bit counter.
// -----------------------------------------------------------------------------
module conv14_frame_feeder
    import conv14_pkg::*;
#(
    parameter int TAIL_LEN  = ENC_MEM,
    parameter int FLUSH_LEN = ENC_MEM
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       enc_in,
    output logic       bit_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       underrun
);

    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_LEN);
    localparam logic [CNT_W-1:0] TAIL_PEN   = CNT_W'(TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);

    state_t           r_state,       w_state_next;
    logic [7:0]       r_shift,       w_shift_next;
    logic [2:0]       r_bit_cnt,     w_bit_cnt_next;
    logic [CNT_W-1:0] r_cnt,         w_cnt_next;
    logic             r_cur_last,    w_cur_last_next;
    logic             r_enc_in,      w_enc_in_next;
    logic             r_bit_valid,   w_bit_valid_next;
    logic             r_frame_start, w_frame_start_next;
    logic             r_frame_end,   w_frame_end_next;
    logic             r_underrun,    w_underrun_next;

    logic       w_consume;
    logic       w_block;
    logic [7:0] w_pf_data;
    logic       w_pf_last;
    logic       w_pf_full;

    assign w_block = (r_state == FLUSH);

    conv14_byte_prefetch u_prefetch (
        .clock     (clock),
        .rst_n     (rst_n),
        .i_data    (s_data),
        .i_last    (s_last),
        .i_valid   (s_valid),
        .i_consume (w_consume),
        .i_block   (w_block),
        .o_ready   (s_ready),
        .o_data    (w_pf_data),
        .o_last    (w_pf_last),
        .o_full    (w_pf_full)
    );

    // The output registers hold the bit currently on enc_in; r_bit_cnt is
    // the index of that bit and r_cnt counts tail bits already shown (1..N)
    // or flush cycles elapsed.
    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_bit_cnt_next     = r_bit_cnt;
        w_cnt_next         = r_cnt;
        w_cur_last_next    = r_cur_last;
        w_enc_in_next      = 1'b0;
        w_bit_valid_next   = 1'b0;
        w_frame_start_next = 1'b0;
        w_frame_end_next   = 1'b0;
        w_underrun_next    = 1'b0;
        w_consume          = 1'b0;

        case (r_state)
            FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            IDLE: begin
                if (w_pf_full) begin
                    w_state_next       = DATA;
                    w_enc_in_next      = w_pf_data[7];
                    w_shift_next       = {w_pf_data[6:0], 1'b0};
                    w_bit_cnt_next     = 3'd0;
                    w_cur_last_next    = w_pf_last;
                    w_bit_valid_next   = 1'b1;
                    w_frame_start_next = 1'b1;
                    w_consume          = 1'b1;
                end
            end

            DATA: begin
                w_bit_valid_next = 1'b1;
                if (r_bit_cnt != 3'd7) begin
                    w_enc_in_next  = r_shift[7];
                    w_shift_next   = {r_shift[6:0], 1'b0};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end else if (!r_cur_last && w_pf_full) begin
                    // Next byte follows directly, no bubble.
                    w_enc_in_next   = w_pf_data[7];
                    w_shift_next    = {w_pf_data[6:0], 1'b0};
                    w_bit_cnt_next  = 3'd0;
                    w_cur_last_next = w_pf_last;
                    w_consume       = 1'b1;
                end else begin
                    // End of payload, either by s_last or because the next
                    // byte did not arrive in time; both end with a clean tail.
                    w_underrun_next  = !r_cur_last;
                    w_state_next     = TAIL;
                    w_cnt_next       = CNT_W'(1);
                    w_frame_end_next = (TAIL_LEN == 1);
                end
            end

            TAIL: begin
                if (r_cnt == TAIL_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next       = r_cnt + 1'b1;
                    w_bit_valid_next = 1'b1;
                    w_frame_end_next = (r_cnt == TAIL_PEN);
                end
            end

            default: w_state_next = FLUSH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state       <= FLUSH;
            r_shift       <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_cnt         <= '0;
            r_cur_last    <= 1'b0;
            r_enc_in      <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_cnt         <= w_cnt_next;
            r_cur_last    <= w_cur_last_next;
            r_enc_in      <= w_enc_in_next;
            r_bit_valid   <= w_bit_valid_next;
            r_frame_start <= w_frame_start_next;
            r_frame_end   <= w_frame_end_next;
            r_underrun    <= w_underrun_next;
        end
    end

    assign enc_in      = r_enc_in;
    assign bit_valid   = r_bit_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_conv14_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_conv14_frame_feeder
// Directed bench for conv14_frame_feeder: flush after reset, single frame
// timing, back-to-back bytes, underrun, byte offered during tail, and reset
// in mid-frame. A 14-bit shift register mirrors the encoder memory.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv14_frame_feeder;

    logic       clock = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       enc_in;
    logic       bit_valid;
    logic       frame_start;
    logic       frame_end;
    logic       underrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [13:0] enc_sr;

    logic cap_bits [0:127];
    int   cap_n, cap_ur_cnt, cap_ur_pos, cap_fs_cnt, cap_fs_pos;
    int   cap_fe_cnt, cap_fe_pos, cap_start_cyc, cap_end_cyc;

    conv14_frame_feeder dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .enc_in      (enc_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        enc_sr <= {enc_sr[12:0], enc_in};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int w = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && w < 60) begin
            tick();
            w++;
        end
        check($sformatf("push_ready_%02h", d), s_ready, 1);
        tick();
        $display("[TB] cycle %0d: byte %02h last=%0b handed over", cyc, d, l);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Waits for the next frame and records it until bit_valid drops.
    task automatic capture();
        int w = 0;
        cap_n = 0; cap_ur_cnt = 0; cap_ur_pos = -1; cap_fs_cnt = 0; cap_fs_pos = -1;
        cap_fe_cnt = 0; cap_fe_pos = -1; cap_start_cyc = -1; cap_end_cyc = -1;
        while (bit_valid !== 1'b1 && w < 60) begin
            tick();
            w++;
        end
        check("frame_appears", bit_valid, 1);
        if (bit_valid !== 1'b1) return;
        cap_start_cyc = cyc;
        while (bit_valid === 1'b1 && cap_n < 128) begin
            cap_bits[cap_n] = enc_in;
            if (underrun === 1'b1)    begin cap_ur_cnt++; cap_ur_pos = cap_n; end
            if (frame_start === 1'b1) begin cap_fs_cnt++; cap_fs_pos = cap_n; end
            if (frame_end === 1'b1)   begin cap_fe_cnt++; cap_fe_pos = cap_n; cap_end_cyc = cyc; end
            cap_n++;
            tick();
        end
        $display("[TB] frame captured: %0d bits, start cycle %0d, end cycle %0d, underruns %0d",
                 cap_n, cap_start_cyc, cap_end_cyc, cap_ur_cnt);
    endtask

    function automatic logic [23:0] payload24(input int n);
        logic [23:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[22:0], cap_bits[i]};
        return v;
    endfunction

    function automatic int tail_ones(input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) if (cap_bits[i] !== 1'b0) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int e1, n1, ur1, urp1, fe1;

        rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_enc_in",      enc_in, 0);
        check("rst_bit_valid",   bit_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_end",   frame_end, 0);
        check("rst_underrun",    underrun, 0);
        check("rst_s_ready",     s_ready, 0);

        // Flush: 14 cycles of s_ready=0 and enc_in=0
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            check($sformatf("flush_ready_%0d", i), s_ready, 0);
            check($sformatf("flush_enc_%0d", i), {enc_in, bit_valid}, 0);
            tick();
        end
        check("idle_ready", s_ready, 1);
        check("idle_bit_valid", bit_valid, 0);
        check("flush_enc_state", enc_sr, 0);

        // Single byte 0xA5 with last, exact cycle timing
        pat = 8'hA5;
        s_data = pat; s_last = 1'b1; s_valid = 1'b1;
        tick();                                   // t+1
        s_valid = 1'b0; s_last = 1'b0;
        check("a5_t1_bit_valid", bit_valid, 0);
        tick();                                   // t+2
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a5_bit%0d", k), enc_in, pat[7-k]);
            check($sformatf("a5_valid%0d", k), bit_valid, 1);
            check($sformatf("a5_start%0d", k), frame_start, (k == 0));
            tick();
        end
        for (int j = 1; j <= 14; j++) begin
            check($sformatf("a5_tail%0d", j), {enc_in, bit_valid}, 1);
            check($sformatf("a5_fend%0d", j), frame_end, (j == 14));
            tick();
        end
        check("a5_after_valid", bit_valid, 0);
        check("a5_after_fend", frame_end, 0);
        check("a5_enc_state", enc_sr, 0);
        $display("[TB] cycle %0d: single-byte frame 0xA5 checked", cyc);

        // Three back-to-back bytes
        fork
            begin
                push(8'hFF, 1'b0);
                push(8'h00, 1'b0);
                push(8'h81, 1'b1);
            end
            capture();
        join
        check("b2b_len", cap_n, 38);
        check("b2b_payload", payload24(24), 24'hFF0081);
        check("b2b_tail_zero", tail_ones(24, 38), 0);
        check("b2b_fs_cnt", cap_fs_cnt, 1);
        check("b2b_fs_pos", cap_fs_pos, 0);
        check("b2b_fe_cnt", cap_fe_cnt, 1);
        check("b2b_fe_pos", cap_fe_pos, 37);
        check("b2b_underrun", cap_ur_cnt, 0);
        check("b2b_enc_state", enc_sr, 0);

        // Underrun; the late byte arrives during the tail and is held
        fork
            begin
                push(8'h3C, 1'b0);
                repeat (11) tick();
                check("tail_offer_ready", s_ready, 1);
                push(8'hC3, 1'b1);
            end
            capture();
        join
        n1 = cap_n; ur1 = cap_ur_cnt; urp1 = cap_ur_pos; fe1 = cap_fe_pos; e1 = cap_end_cyc;
        check("ur_len", n1, 22);
        check("ur_payload", payload24(8), 24'h00003C);
        check("ur_tail_zero", tail_ones(8, 22), 0);
        check("ur_cnt", ur1, 1);
        check("ur_pos", urp1, 8);
        check("ur_fe_pos", fe1, 21);
        check("ur_enc_state", enc_sr, 0);
        capture();
        check("late_len", cap_n, 22);
        check("late_payload", payload24(8), 24'h0000C3);
        check("late_fs_pos", cap_fs_pos, 0);
        check("late_underrun", cap_ur_cnt, 0);
        check("late_gap", cap_start_cyc - e1, 2);

        // Reset during payload bit 3, with a second byte waiting in prefetch
        push(8'hF0, 1'b0);                        // now at t+1
        push(8'h0F, 1'b0);                        // now at t+2, bit 0 shown
        tick(); tick(); tick();                   // t+5, bit 3
        check("mid_bit3", {enc_in, bit_valid}, 2'b11);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_outputs", {enc_in, bit_valid, frame_start, frame_end, underrun, s_ready}, 0);
        begin
            int bad = 0;
            for (int i = 0; i < 14; i++) begin
                if (s_ready !== 1'b0 || bit_valid !== 1'b0 || frame_end !== 1'b0) bad++;
                tick();
            end
            check("mid_flush_quiet", bad, 0);
            check("mid_flush_ready", s_ready, 1);
            bad = 0;
            for (int i = 0; i < 6; i++) begin
                if (bit_valid !== 1'b0 || frame_end !== 1'b0) bad++;
                tick();
            end
            check("mid_prefetch_dropped", bad, 0);
            check("mid_enc_state", enc_sr, 0);
        end
        $display("[TB] cycle %0d: mid-frame reset checked", cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
